// File: rtl/drive_pkg.sv
// Shared encodings for the line-follower drive sequencer.
// Mode and FSM state types plus the sensor pattern map.
package drive_pkg;

   typedef enum logic [1:0] {
      MODE_STOP  = 2'b00,
      MODE_LEFT  = 2'b01,
      MODE_RIGHT = 2'b10,
      MODE_FWD   = 2'b11
   } mode_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FOLLOW  = 3'd1,
      SEARCH  = 3'd2,
      BLOCKED = 3'd3,
      FAULT   = 3'd4
   } state_t;

   // 101 and 000 carry no steering information, so keep the current mode
   function automatic mode_t pattern_mode(
      input logic [2:0] pat,
      input mode_t      cur
   );
      mode_t m;
      m = cur;
      unique case (pat)
         3'b010, 3'b111: m = MODE_FWD;
         3'b100, 3'b110: m = MODE_LEFT;
         3'b001, 3'b011: m = MODE_RIGHT;
         default:        m = cur;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability filter.
// Output follows the synced value once it has held STABLE_CYC cycles.
module sync_debounce #(
   parameter int          W          = 3,
   parameter int unsigned STABLE_CYC = 100_000,
   parameter int          CNT_W      = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
   localparam logic [CNT_W-1:0] CNT_T   = CNT_W'(STABLE_CYC - 1);

   logic [W-1:0]     s1;
   logic [W-1:0]     s2;
   logic [W-1:0]     last;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= '0;
         s2   <= '0;
         last <= '0;
         cnt  <= '0;
         dout <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 != last) begin
            last <= s2;
            cnt  <= CNT_W'(1);
         end else begin
            if (cnt != CNT_MAX)
               cnt <= cnt + 1'b1;
            if (cnt >= CNT_T)
               dout <= last;
         end
      end
   end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower drive sequencer: debounced sensors in, motor mode out.
// Handles turn hold, lost-line search, obstacle blocking and fault lockout.
module line_follow_ctrl
   import drive_pkg::*;
#(
   parameter int          CNT_W        = 32,
   parameter int unsigned DEBOUNCE_CYC = 100_000,
   parameter int unsigned MIN_TURN_CYC = 5_000_000,
   parameter int unsigned LOST_CYC     = 20_000_000,
   parameter int unsigned SEARCH_CYC   = 300_000_000,
   parameter int unsigned CLEAR_CYC    = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [2:0] sensor,
   input  logic       obstacle,
   output logic [1:0] mode,
   output logic [2:0] state,
   output logic       fault
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_TURN_CYC);
   localparam logic [CNT_W-1:0] LOST_T   = CNT_W'(LOST_CYC - 1);
   localparam logic [CNT_W-1:0] SRCH_T   = CNT_W'(SEARCH_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_T    = CNT_W'(CLEAR_CYC - 1);

   logic [2:0]       filt;
   logic             obs1;
   logic             obs_s;
   state_t           st_q,   st_n;
   mode_t            mode_q, mode_n;
   mode_t            last_dir;
   mode_t            req;
   logic [CNT_W-1:0] hold_q;
   logic [CNT_W-1:0] lost_q, lost_n;
   logic [CNT_W-1:0] srch_q, srch_n;
   logic [CNT_W-1:0] clr_q,  clr_n;
   logic             hold_clr;
   logic             turn_hold;

   sync_debounce #(
      .W          (3),
      .STABLE_CYC (DEBOUNCE_CYC),
      .CNT_W      (CNT_W)
   ) u_sens (
      .clk  (clk),
      .rst  (rst),
      .din  (sensor),
      .dout (filt)
   );

   assign req       = pattern_mode(filt, mode_q);
   assign turn_hold = (mode_q == MODE_LEFT || mode_q == MODE_RIGHT)
                      && (hold_q < HOLD_MAX);

   always_comb begin
      st_n     = st_q;
      mode_n   = mode_q;
      lost_n   = lost_q;
      srch_n   = srch_q;
      clr_n    = clr_q;
      hold_clr = 1'b0;
      if (!enable) begin
         st_n     = IDLE;
         mode_n   = MODE_STOP;
         lost_n   = '0;
         srch_n   = '0;
         clr_n    = '0;
         hold_clr = 1'b1;
      end else if (obs_s && st_q != FAULT) begin
         st_n   = BLOCKED;
         mode_n = MODE_STOP;
         clr_n  = '0;
      end else begin
         unique case (st_q)
            IDLE: begin
               st_n     = FOLLOW;
               mode_n   = MODE_STOP;
               lost_n   = '0;
               hold_clr = 1'b1;
            end
            FOLLOW: begin
               lost_n = '0;
               if (!turn_hold)
                  mode_n = req;
               if (filt == 3'b000) begin
                  lost_n = lost_q + 1'b1;
                  if (lost_q >= LOST_T) begin
                     st_n   = SEARCH;
                     mode_n = last_dir;
                     lost_n = lost_q;
                     srch_n = '0;
                  end
               end
            end
            SEARCH: begin
               mode_n = last_dir;
               if (filt != 3'b000) begin
                  st_n     = FOLLOW;
                  mode_n   = req;
                  lost_n   = '0;
                  hold_clr = 1'b1;
               end else if (srch_q >= SRCH_T) begin
                  st_n   = FAULT;
                  mode_n = MODE_STOP;
               end else begin
                  srch_n = srch_q + 1'b1;
               end
            end
            BLOCKED: begin
               mode_n = MODE_STOP;
               if (clr_q >= CLR_T) begin
                  st_n     = FOLLOW;
                  mode_n   = req;
                  lost_n   = '0;
                  hold_clr = 1'b1;
               end else begin
                  clr_n = clr_q + 1'b1;
               end
            end
            FAULT: begin
               mode_n = MODE_STOP;
            end
            default: begin
               st_n   = IDLE;
               mode_n = MODE_STOP;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         obs1     <= 1'b0;
         obs_s    <= 1'b0;
         st_q     <= IDLE;
         mode_q   <= MODE_STOP;
         last_dir <= MODE_LEFT;
         hold_q   <= '0;
         lost_q   <= '0;
         srch_q   <= '0;
         clr_q    <= '0;
      end else begin
         obs1   <= obstacle;
         obs_s  <= obs1;
         st_q   <= st_n;
         mode_q <= mode_n;
         lost_q <= lost_n;
         srch_q <= srch_n;
         clr_q  <= clr_n;
         if (mode_n == MODE_LEFT || mode_n == MODE_RIGHT)
            last_dir <= mode_n;
         if (hold_clr || mode_n != mode_q)
            hold_q <= '0;
         else if (hold_q != HOLD_MAX)
            hold_q <= hold_q + 1'b1;
      end
   end

   assign mode  = mode_q;
   assign state = st_q;
   assign fault = (st_q == FAULT);

endmodule

// File: doc/line_follow_ctrl.md
Name: line_follow_ctrl

Overview:
- Autonomous drive sequencer that produces the 2-bit `mode` command consumed by the motor block: 00 stop, 01 left, 10 right, 11 forward.
- Input side: 3-bit line-tracker sensor vector and an obstacle flag.
- Internals: input synchronisation and debounce, minimum turn-hold, lost-line search, obstacle blocking and a fault lockout.
- Placement: sits between the sensor pins and the motor block in the car top level.

Parameters:
- CNT_W, 32, width of all internal timers.
- DEBOUNCE_CYC, 100_000, cycles the synced sensor pattern must stay stable before it is accepted (1 ms at 100 MHz).
- MIN_TURN_CYC, 5_000_000, minimum cycles a left/right mode is held before any change.
- LOST_CYC, 20_000_000, consecutive cycles of filtered pattern 000 in FOLLOW before entering SEARCH.
- SEARCH_CYC, 300_000_000, maximum cycles spent in SEARCH before FAULT.
- CLEAR_CYC, 10_000_000, consecutive obstacle-free cycles required to leave BLOCKED.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request; level-sensitive
- sensor  in  3  {L,M,R} raw line sensors, asynchronous, 1 = line seen
- obstacle  in  1  raw obstacle flag, asynchronous, 1 = too close
- mode  out  2  registered motor command to the motor block
- state  out  3  current FSM state, for debug/LEDs
- fault  out  1  high while in FAULT

Behaviour:
- Reset values (rst high at a clk edge): mode=00, state=IDLE, fault=0.
  - All counters and sync flops are cleared; the filtered pattern is cleared to 000.
  - last_dir is set to 01.
- Synchronisers: sensor and obstacle each pass through 2 flops.
- Debounce (sensor only):
  - A stable counter restarts whenever the synced value changes.
  - The filtered pattern updates when the synced value has held for DEBOUNCE_CYC cycles.
  - Sensor-to-mode latency = 2 + DEBOUNCE_CYC + 1 cycles.
- Obstacle has no debounce: FOLLOW/SEARCH to mode 00 takes 3 cycles after obstacle rises.
- Pattern map in FOLLOW (filtered pattern to requested mode):
  - 010, 111 -> 11
  - 100, 110 -> 01
  - 001, 011 -> 10
  - 101, 000 -> keep current mode
- last_dir updates whenever mode is written with 01 or 10.
- Turn hold:
  - hold counter clears whenever mode is written with a different value.
  - While mode is 01/10 and hold < MIN_TURN_CYC, requested changes are deferred.
  - After the hold expires, a still-pending request takes effect on the next cycle.
  - Changes from 11 and from 00 are immediate.
- Priority each cycle: rst > enable=0 > obstacle > state-specific logic.
- FSM:
  - IDLE: mode 00. enable=1 -> FOLLOW.
  - FOLLOW: mode from the pattern map and hold rule.
    - obstacle_s=1 -> BLOCKED.
    - lost counter counts consecutive filtered 000; at LOST_CYC -> SEARCH.
  - SEARCH: mode=last_dir (hold rule not applied).
    - filtered != 000 -> FOLLOW with hold cleared.
    - obstacle_s=1 -> BLOCKED.
    - search counter reaches SEARCH_CYC -> FAULT.
  - BLOCKED: mode 00.
    - clear counter counts consecutive obstacle_s=0; at CLEAR_CYC -> FOLLOW with lost and hold cleared.
    - If the filtered pattern is 000 on exit, FOLLOW emits 00 until a line is seen or LOST_CYC expires.
    - obstacle reassertion restarts the clear counter.
  - FAULT: mode 00, fault=1. Leaves only via enable=0 (-> IDLE) or rst.
  - Any state with enable=0 -> IDLE next cycle; all timers cleared; last_dir kept.
- Counter rules:
  - Every timer saturates at its terminal value; none wrap.
  - A timer is cleared on entry to the state that uses it.
- Boundary cases:
  - Obstacle and a line change on the same cycle: BLOCKED wins.
  - Sensor bouncing faster than DEBOUNCE_CYC never updates the filtered pattern.
  - enable dropping mid-SEARCH or mid-hold aborts immediately.
  - rst mid-operation returns every output to its reset value on the next edge.

Decomposition:
- Shared package drive_pkg:
  - mode encodings MODE_STOP=00, MODE_LEFT=01, MODE_RIGHT=10, MODE_FWD=11.
  - FSM state encodings IDLE=0, FOLLOW=1, SEARCH=2, BLOCKED=3, FAULT=4.
- One sub-module, sync_debounce:
  - Parameters W and STABLE_CYC: 2-flop synchroniser plus stable counter.
  - Instantiated with W=3 for sensor.
  - Obstacle uses a plain 2-flop synchroniser inside the top.

Test Plan (overrides DEBOUNCE_CYC=4, MIN_TURN_CYC=8, LOST_CYC=16, SEARCH_CYC=32, CLEAR_CYC=6):
- Reset then enable=1, sensor=010 held -> state IDLE->FOLLOW next cycle; mode=11 exactly 7 cycles after sensor is applied; fault=0.
- sensor 010 to 100 -> mode=01 after 7 cycles. Then 001 two cycles later -> mode stays 01 until hold reaches 8, then 10 on the following cycle.
- sensor=000 held in FOLLOW -> state=SEARCH after 16 filtered-000 cycles with mode=last_dir (01). Continue 000 -> FAULT after 32 more cycles, mode=00, fault=1. enable=0 -> IDLE, fault=0.
- obstacle=1 pulse during FOLLOW (mode 11) -> mode=00 3 cycles later, state=BLOCKED. Obstacle low -> FOLLOW and mode=11 after 2+6 cycles. Re-pulse at clear count 4 -> counter restarts.
- sensor toggling 010/110 every 2 cycles -> filtered pattern and mode unchanged.
- rst asserted while in SEARCH -> next edge mode=00, state=IDLE, fault=0, last_dir=01.
